afpm_byte_sequencer: RTL

Control block sitting between the 8-bit Tiny Tapeout pad interface and the 16-bit logarithmic approximate FP16 multiplier. It assembles two byte-serial FP16 operands (low byte first), launches one multiply, and waits for completion under a watchdog. It then streams the 16-bit product back out as two bytes over a valid/ready handshake. This gives the multiplier a clean start/done contract and lets the top-level wrapper remain pure wiring.

---
 rtl/afpm_pkg.sv | 29 ++
 rtl/afpm_byte_sequencer_if.sv | 35 +++
 rtl/afpm_wdog_cnt.sv | 33 +++
 rtl/afpm_byte_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/afpm_pkg.sv
// Shared types and constants for the FP16 byte sequencer.
//   seq_state_t     : sequencer FSM states
//   fp16_bytes_t    : FP16 word viewed as high/low bytes
//   FP16_QNAN       : result substituted when the watchdog fires
//   DEFAULT_TIMEOUT : default watchdog limit in WAIT cycles
package afpm_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned CNT_W  = 8;

  localparam logic [WORD_W-1:0] FP16_QNAN = 16'h7E00;
  localparam int unsigned DEFAULT_TIMEOUT = 16;

  typedef enum logic [2:0] {
    ST_LOAD_LO = 3'd0,
    ST_LOAD_HI = 3'd1,
    ST_START   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_OUT_LO  = 3'd4,
    ST_OUT_HI  = 3'd5
  } seq_state_t;

  typedef struct packed {
    logic [BYTE_W-1:0] hi;
    logic [BYTE_W-1:0] lo;
  } fp16_bytes_t;

endpackage

// File: rtl/afpm_byte_sequencer_if.sv
// Bus bundle between the sequencer and its surroundings.
//   in_*   : byte-pair operand stream (valid/ready)
//   mul_*  : start/done contract with the FP16 multiplier
//   out_*  : result byte stream (valid/ready, last on high byte)
// master = sequencer side, slave = pad wrapper / multiplier side.
interface afpm_byte_sequencer_if;
  import afpm_pkg::*;

  logic              in_valid;
  logic [BYTE_W-1:0] in_a;
  logic [BYTE_W-1:0] in_b;
  logic              in_ready;

  logic [WORD_W-1:0] mul_a;
  logic [WORD_W-1:0] mul_b;
  logic              mul_start;
  logic              mul_done;
  logic [WORD_W-1:0] mul_result;

  logic [BYTE_W-1:0] out_byte;
  logic              out_valid;
  logic              out_last;
  logic              out_ready;

  modport master (
    input  in_valid, in_a, in_b, mul_done, mul_result, out_ready,
    output in_ready, mul_a, mul_b, mul_start, out_byte, out_valid, out_last
  );

  modport slave (
    output in_valid, in_a, in_b, mul_done, mul_result, out_ready,
    input  in_ready, mul_a, mul_b, mul_start, out_byte, out_valid, out_last
  );

endinterface

// File: rtl/afpm_wdog_cnt.sv
// Watchdog counter for the WAIT state.
//   clk, rst : clock, synchronous active-high reset
//   clr      : zero the count (takes priority over en)
//   en       : advance the count by one
//   hit      : count has reached TIMEOUT-1
module afpm_wdog_cnt
  import afpm_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam logic [CNT_W-1:0] HIT_VAL = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;

  // Count register
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign hit = (cnt_q == HIT_VAL);

endmodule

// File: rtl/afpm_byte_sequencer.sv
// Byte-serial front end for the approximate FP16 multiplier: collects two
// byte pairs (low first), launches one multiply, waits under a watchdog and
// returns the product as two bytes (low first, out_last on the high byte).
//   clk, rst : clock, synchronous active-high reset
//   bus      : operand stream, multiplier contract and result stream
//   clr_err  : clears the sticky watchdog flag
//   busy     : high outside LOAD_LO
//   err      : sticky watchdog flag (set beats clear)
//   op_count : completed operations, wraps at 256
module afpm_byte_sequencer
  import afpm_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         rst,
  afpm_byte_sequencer_if.master        bus,
  input  logic                         clr_err,
  output logic                         busy,
  output logic                         err,
  output logic [BYTE_W-1:0]            op_count
);

  seq_state_t        state_q, state_d;
  fp16_bytes_t       a_q, a_d, b_q, b_d, r_q, r_d;
  logic              err_d;
  logic [BYTE_W-1:0] op_count_d;

  logic              in_ready_q, in_ready_d;
  logic              mul_start_q, mul_start_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [BYTE_W-1:0] out_byte_q, out_byte_d;
  logic              busy_d;

  logic in_hs, out_hs;
  logic wd_clr, wd_en, wd_hit;

  assign in_hs  = bus.in_valid && in_ready_q;
  assign out_hs = out_valid_q && bus.out_ready;

  // Counter restarts in START and counts WAIT cycles without completion
  assign wd_clr = (state_q == ST_START);
  assign wd_en  = (state_q == ST_WAIT) && !bus.mul_done;

  afpm_wdog_cnt #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk (clk),
    .rst (rst),
    .clr (wd_clr),
    .en  (wd_en),
    .hit (wd_hit)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_LOAD_LO;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      err      <= 1'b0;
      op_count <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      err      <= err_d;
      op_count <= op_count_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    r_d        = r_q;
    err_d      = err;
    op_count_d = op_count;

    if (clr_err) begin
      err_d = 1'b0;
    end

    case (state_q)
      ST_LOAD_LO: begin
        if (in_hs) begin
          a_d.lo  = bus.in_a;
          b_d.lo  = bus.in_b;
          state_d = ST_LOAD_HI;
        end
      end
      ST_LOAD_HI: begin
        if (in_hs) begin
          a_d.hi  = bus.in_a;
          b_d.hi  = bus.in_b;
          state_d = ST_START;
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A completion on the watchdog's final cycle still wins
        if (bus.mul_done) begin
          r_d     = fp16_bytes_t'(bus.mul_result);
          state_d = ST_OUT_LO;
        end else if (wd_hit) begin
          r_d     = fp16_bytes_t'(FP16_QNAN);
          err_d   = 1'b1;
          state_d = ST_OUT_LO;
        end
      end
      ST_OUT_LO: begin
        if (out_hs) begin
          state_d = ST_OUT_HI;
        end
      end
      ST_OUT_HI: begin
        if (out_hs) begin
          op_count_d = op_count + BYTE_W'(1);
          state_d    = ST_LOAD_LO;
        end
      end
      default: begin
        state_d = ST_LOAD_LO;
      end
    endcase
  end

  // Output decode from the upcoming state so every output is a flop
  always_comb begin
    in_ready_d  = 1'b0;
    mul_start_d = 1'b0;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    out_byte_d  = '0;
    busy_d      = 1'b1;

    case (state_d)
      ST_LOAD_LO: begin
        in_ready_d = 1'b1;
        busy_d     = 1'b0;
      end
      ST_LOAD_HI: begin
        in_ready_d = 1'b1;
      end
      ST_START: begin
        mul_start_d = 1'b1;
      end
      ST_OUT_LO: begin
        out_valid_d = 1'b1;
        out_byte_d  = r_d.lo;
      end
      ST_OUT_HI: begin
        out_valid_d = 1'b1;
        out_last_d  = 1'b1;
        out_byte_d  = r_d.hi;
      end
      default: begin
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_q  <= 1'b1;
      mul_start_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_byte_q  <= '0;
      busy        <= 1'b0;
    end else begin
      in_ready_q  <= in_ready_d;
      mul_start_q <= mul_start_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_byte_q  <= out_byte_d;
      busy        <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mul_start = mul_start_q;
  assign bus.mul_a     = a_q;
  assign bus.mul_b     = b_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_byte  = out_byte_q;

endmodule
